// File: rtl/iir_fold_pkg.sv
// Shared types and Q10.10 constants for the three-fold IIR filter and its input feeder.
package iir_fold_pkg;

    localparam int DATA_W = 20;
    localparam int FRAC_W = 10;
    localparam int FOLD   = 3;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [1:0]               phase_t;

    localparam phase_t PHASE_LAST = phase_t'(FOLD - 1);

    // Q10.10 constants shared with the filter: 1.0 and the 8/4/2 coefficients.
    localparam sample_t ONE    = sample_t'(1) <<< FRAC_W;
    localparam sample_t COEF_8 = 20'sh02000;
    localparam sample_t COEF_4 = 20'sh01000;
    localparam sample_t COEF_2 = 20'sh00800;

endpackage

// File: rtl/iir_fold_feeder_if.sv
// Upstream valid/ready sample stream into the IIR fold feeder.
interface iir_fold_feeder_if;
    import iir_fold_pkg::*;

    sample_t s_data;
    logic    s_valid;
    logic    s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/iir_fold_feeder_sample_fifo.sv
// Sample FIFO for the feeder: storage array, wrapping pointers and an occupancy
// count that is the only source of full/empty.
module sample_fifo
    import iir_fold_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  sample_t       push_data_i,
    input  logic          pop_i,
    output sample_t       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    sample_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; level gates every read,
    // so stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/iir_fold_feeder.sv
// IIR fold feeder: buffers upstream samples and presents one held sample per
// FOLD-clock frame, zero-stuffing on underrun. Optional clamp via IIR_FEED_SAT_EN.
module iir_fold_feeder
    import iir_fold_pkg::*;
#(
    parameter int      DEPTH   = 8,
    parameter sample_t SAT_LIM = ONE <<< 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    iir_fold_feeder_if.slave             up,
    output sample_t                      x_out,
    output phase_t                       phase,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         underrun,
    output logic                         sat_hit
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SAT_LIM <= 0) begin : g_bad_cfg
        $error("iir_fold_feeder: DEPTH must be a power of two >= 2 and SAT_LIM positive");
    end

    phase_t  phase_q, phase_d;
    sample_t x_q, x_d;
    logic    under_q, under_d;
    logic    boundary;
    logic    push, pop;
    logic    full, empty;
    sample_t head, wr_data;

    assign push       = up.s_valid && up.s_ready;
    assign up.s_ready = !full;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        boundary = (phase_q == PHASE_LAST);
        phase_d  = boundary ? '0 : phase_q + phase_t'(1);
        pop      = boundary && !empty;
        x_d      = x_q;
        under_d  = 1'b0;
        if (boundary) begin
            x_d     = empty ? '0 : head;
            under_d = empty;
        end
    end

`ifdef IIR_FEED_SAT_EN
    logic sat_q, sat_d;

    // Signed clamp to [-SAT_LIM, +SAT_LIM]; only an accepted push can flag a hit.
    always_comb begin
        wr_data = up.s_data;
        sat_d   = 1'b0;
        if (up.s_data > SAT_LIM) begin
            wr_data = SAT_LIM;
            sat_d   = push;
        end else if (up.s_data < -SAT_LIM) begin
            wr_data = -SAT_LIM;
            sat_d   = push;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_hit = sat_q;
`else
    assign wr_data = up.s_data;
    assign sat_hit = 1'b0;
`endif

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            x_q     <= '0;
            under_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            x_q     <= x_d;
            under_q <= under_d;
        end
    end

    assign phase    = phase_q;
    assign x_out    = x_q;
    assign underrun = under_q;

endmodule
